mem_req_queue: RTL
==================

MEM_REQ_QUEUE -- requirements
Module: mem_req_queue

Interface
REQ-001: Parameter DATA_WIDTH, default 32, width of the request payload.
REQ-002: Parameter DEPTH, default 4, queue entries; SHALL be a power of two and at least 2.
REQ-003: Parameter ST_TYPE_WIDTH, default 3, store-type field width.
REQ-004: Parameter LD_TYPE_WIDTH, default 3, load-type field width.
REQ-005: clk  input  1  clock; all state updates on the rising edge.
REQ-006: rst_n  input  1  reset, synchronous, active-low.
REQ-007: stall  input  1  pipeline stall; freezes all state.
REQ-008: flush  input  1  pipeline flush; discards all queued requests.
REQ-009: in_valid  input  1  upstream has an instruction this cycle.
REQ-010: in_ready  output  1  queue can accept a memory request this cycle.
REQ-011: in_st_type  input  ST_TYPE_WIDTH  store type; nonzero means store.
REQ-012: in_ld_type  input  LD_TYPE_WIDTH  load type; nonzero means load.
REQ-013: in_data  input  DATA_WIDTH  request payload.
REQ-014: out_valid  output  1  head entry is valid.
REQ-015: out_ready  input  1  downstream accepts the head entry.
REQ-016: out_st_type  output  ST_TYPE_WIDTH  head store type.
REQ-017: out_ld_type  output  LD_TYPE_WIDTH  head load type.
REQ-018: out_data  output  DATA_WIDTH  head payload.
REQ-019: count  output  clog2(DEPTH+1)  number of occupied entries.
REQ-020: st_pending  output  clog2(DEPTH+1)  number of queued entries with nonzero store type.

Function
REQ-021: Memory op: in_st_type or in_ld_type nonzero. Non-memory op: both fields zero.
REQ-022: Non-memory ops with in_valid=1 SHALL be dropped without enqueue, regardless of in_ready.
REQ-023: in_ready SHALL be 1 only when count < DEPTH and stall=0; there is no same-cycle full-bypass.
REQ-024: Enqueue when in_valid & in_ready & memory op & ~flush; the entry is written at the write pointer, and the pointer advances modulo DEPTH.
REQ-025: out_valid SHALL equal (count != 0).
REQ-026: When count == 0, out_st_type, out_ld_type and out_data SHALL be 0; otherwise they SHALL show the head entry combinationally.
REQ-027: Dequeue when out_valid & out_ready & ~stall & ~flush; the read pointer advances modulo DEPTH.
REQ-028: Simultaneous enqueue and dequeue SHALL leave count unchanged and preserve FIFO order.
REQ-029: st_pending SHALL increment on enqueue of a store and decrement on dequeue of a store, net zero if both happen in the same cycle.
REQ-030: An entry with both type fields nonzero SHALL count as a store.
REQ-031: Priority order: reset > stall > flush > enqueue/dequeue.
REQ-032: stall=1 SHALL hold pointers, count, st_pending and storage; flush asserted during stall is ignored.
REQ-033: flush=1 (stall=0) SHALL clear pointers, count and st_pending in one cycle and suppress that cycle's enqueue and dequeue.
REQ-034: Latency: an entry enqueued at edge N SHALL be visible on out_* after edge N, provided it reaches the queue head.

Reset
REQ-035: With rst_n=0 at a clock edge, pointers, count and st_pending SHALL become 0, so out_valid=0 and out_* = 0.
REQ-036: Storage contents need not be reset; they SHALL never be visible while count == 0.
REQ-037: Reset asserted mid-operation SHALL discard all entries, irrespective of stall or flush.

Verification
REQ-038: Scenario 1: reset, then enqueue a load (ld=1, data=0xA5), out_ready=0 -> next cycle out_valid=1, out_data=0xA5, count=1, st_pending=0.
REQ-039: Scenario 2: with DEPTH=4, enqueue 4 stores (data 1..4), out_ready=0 -> count=4, st_pending=4, in_ready=0; a 5th request is not accepted.
REQ-040: Scenario 3: queue full, out_ready=1 and in_valid=0 -> pops in order 1,2,3,4; pointers wrap; then enqueue 5 -> out_data=5.
REQ-041: Scenario 4: in_valid=1 with both type fields zero for 3 cycles -> count stays 0, out_valid=0.
REQ-042: Scenario 5: count=2, flush=1 with a valid enqueue in the same cycle -> count=0, st_pending=0, out_data=0; under stall=1 the same flush leaves count=2.
REQ-043: Scenario 6: count=1 and a simultaneous store enqueue plus store dequeue -> count=1, st_pending unchanged, out_data equals the new entry.

Source files
------------

// File: rtl/mem_req_queue.sv
// Memory request queue: a small FIFO that accepts only load/store requests and
// tracks how many queued entries are stores.
module mem_req_queue #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4,
    parameter int ST_TYPE_WIDTH = 3,
    parameter int LD_TYPE_WIDTH = 3,
    localparam int CW           = $clog2(DEPTH + 1),
    localparam int PW           = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ST_TYPE_WIDTH-1:0] in_st_type,
    input  logic [LD_TYPE_WIDTH-1:0] in_ld_type,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ST_TYPE_WIDTH-1:0] out_st_type,
    output logic [LD_TYPE_WIDTH-1:0] out_ld_type,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [CW-1:0]            count,
    output logic [CW-1:0]            st_pending
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [ST_TYPE_WIDTH-1:0] st_mem   [DEPTH];
    logic [LD_TYPE_WIDTH-1:0] ld_mem   [DEPTH];
    logic [DATA_WIDTH-1:0]    data_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          mem_op;
    logic          enq;
    logic          deq;
    logic          enq_store;
    logic          deq_store;
    logic [CW-1:0] count_next;
    logic [CW-1:0] st_pending_next;

    assign mem_op    = (|in_st_type) | (|in_ld_type);
    assign in_ready  = (count < FULL_COUNT) && !stall;
    assign out_valid = (count != '0);

    assign enq       = in_valid && in_ready && mem_op && !flush;
    assign deq       = out_valid && out_ready && !stall && !flush;
    // A request with both type fields set is a store for pending-store tracking.
    assign enq_store = enq && (|in_st_type);
    assign deq_store = deq && (|st_mem[rd_ptr]);

    // Head is gated so stale storage never leaks out while the queue is empty.
    assign out_st_type = out_valid ? st_mem[rd_ptr]   : '0;
    assign out_ld_type = out_valid ? ld_mem[rd_ptr]   : '0;
    assign out_data    = out_valid ? data_mem[rd_ptr] : '0;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        count_next      = count;
        st_pending_next = st_pending;
        case ({enq, deq})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
        case ({enq_store, deq_store})
            2'b10:   st_pending_next = st_pending + CW'(1);
            2'b01:   st_pending_next = st_pending - CW'(1);
            default: st_pending_next = st_pending;
        endcase
    end

    // NOTE: storage is deliberately left out of reset; the count gate on out_* hides it.
    always_ff @(posedge clk) begin
        if (enq) begin
            st_mem[wr_ptr]   <= in_st_type;
            ld_mem[wr_ptr]   <= in_ld_type;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            st_pending <= '0;
        end else if (stall) begin
            wr_ptr     <= wr_ptr;
            rd_ptr     <= rd_ptr;
            count      <= count;
            st_pending <= st_pending;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            st_pending <= '0;
        end else begin
            // Pointer widths equal log2(DEPTH), so natural overflow is the modulo wrap.
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            count      <= count_next;
            st_pending <= st_pending_next;
        end
    end

endmodule
